// File: rtl/multi_lock_pkg.sv
// Shared constants and FSM encoding for the multi-lock manager and its bench.
package multi_lock_pkg;

  localparam logic [7:0] LOCK_OP   = 8'h04;
  localparam logic [7:0] UNLOCK_OP = 8'h06;

  localparam int OPC_LSB   = 0;
  localparam int ID_LSB    = 8;
  localparam int GRANT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/multi_lock_manager_if.sv
// Request/response AXI-Stream pair between accelerators and the lock manager.
interface multi_lock_manager_if #(
  parameter int MAX_ACCS = 16
);
  localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;

  // Both channels: a beat transfers on a rising edge where tvalid && tready;
  // once tvalid is high, tdata/tid/tdest stay stable until that edge.
  logic          lock_in_tvalid;
  logic          lock_in_tready;
  logic [AW-1:0] lock_in_tid;
  logic [63:0]   lock_in_tdata;

  logic          lock_out_tvalid;
  logic          lock_out_tready;
  logic [AW-1:0] lock_out_tdest;
  logic [63:0]   lock_out_tdata;
  logic          lock_out_tlast;

  modport master (
    output lock_in_tvalid, lock_in_tid, lock_in_tdata,
    input  lock_in_tready,
    input  lock_out_tvalid, lock_out_tdest, lock_out_tdata, lock_out_tlast,
    output lock_out_tready
  );

  modport slave (
    input  lock_in_tvalid, lock_in_tid, lock_in_tdata,
    output lock_in_tready,
    output lock_out_tvalid, lock_out_tdest, lock_out_tdata, lock_out_tlast,
    input  lock_out_tready
  );

endinterface

// File: rtl/multi_lock_manager_rr_pick.sv
// Round-robin selector: first set mask bit at or after start, wrapping modulo MAX_ACCS.
module rr_pick #(
  parameter  int MAX_ACCS = 16,
  localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic [MAX_ACCS-1:0] mask,
  input  logic [AW-1:0]       start,
  output logic [AW-1:0]       index,
  output logic                found
);

  logic [MAX_ACCS-1:0] rotated;
  logic [AW-1:0]       offset;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (AW+1)'(MAX_ACCS)) s = s - (AW+1)'(MAX_ACCS);
    return s[AW-1:0];
  endfunction

  // Rotate so bit 0 is the start position, priority-encode, then rotate back.
  always_comb begin
    rotated = '0;
    offset  = '0;
    for (int k = 0; k < MAX_ACCS; k++) begin
      rotated[k] = mask[wrap_add(start, AW'(k))];
    end
    for (int k = MAX_ACCS - 1; k >= 0; k--) begin
      if (rotated[k]) offset = AW'(k);
    end
    found = |rotated;
    index = wrap_add(start, offset);
  end

endmodule

// File: rtl/multi_lock_manager.sv
// Serves NUM_LOCKS named locks to MAX_ACCS accelerators, optionally parking
// contended LOCK requests and handing the lock over round-robin on UNLOCK.
module multi_lock_manager
  import multi_lock_pkg::*;
#(
  parameter int MAX_ACCS      = 16,
  parameter int NUM_LOCKS     = 4,
  parameter int QUEUE_WAITERS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  multi_lock_manager_if.slave  lock_if,
  output logic [NUM_LOCKS-1:0] lock_busy,
  output logic                 err,
  output state_e               dbg_state
);

  localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;
  localparam int LW = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       tid_q, tid_d;
  logic [7:0]          opc_q, opc_d;
  logic [7:0]          id_q, id_d;
  logic [AW-1:0]       owner_q  [NUM_LOCKS];
  logic [AW-1:0]       owner_d  [NUM_LOCKS];
  logic [MAX_ACCS-1:0] waiter_q [NUM_LOCKS];
  logic [MAX_ACCS-1:0] waiter_d [NUM_LOCKS];
  logic [NUM_LOCKS-1:0] valid_q, valid_d;
  logic                in_rdy_q, in_rdy_d;
  logic                out_vld_q, out_vld_d;
  logic [AW-1:0]       dest_q, dest_d;
  logic [63:0]         data_q, data_d;
  logic                err_q, err_d;

  logic [LW-1:0]       lock_idx;
  logic                in_range;
  logic [AW-1:0]       sel_owner;
  logic                sel_valid;
  logic [MAX_ACCS-1:0] sel_waiter;
  logic [AW-1:0]       rr_start;
  logic [AW-1:0]       pick_idx;
  logic                pick_found;
  logic                unused_tdata;

  assign unused_tdata = ^lock_if.lock_in_tdata[63:16];

  // Array reads are only acted upon when in_range, so an index past
  // NUM_LOCKS for non-power-of-two sizes is harmless.
  assign lock_idx   = id_q[LW-1:0];
  assign in_range   = int'(id_q) < NUM_LOCKS;
  assign sel_owner  = owner_q[lock_idx];
  assign sel_valid  = valid_q[lock_idx];
  assign sel_waiter = waiter_q[lock_idx];
  assign rr_start   = (sel_owner == AW'(MAX_ACCS - 1)) ? '0 : sel_owner + AW'(1);

  rr_pick #(.MAX_ACCS(MAX_ACCS)) u_rr_pick (
    .mask  (sel_waiter),
    .start (rr_start),
    .index (pick_idx),
    .found (pick_found)
  );

  function automatic logic [63:0] resp_word(input logic [7:0] id, input logic grant);
    logic [63:0] w;
    w = '0;
    w[ID_LSB +: 8] = id;
    w[GRANT_BIT]   = grant;
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    tid_d    = tid_q;
    opc_d    = opc_q;
    id_d     = id_q;
    owner_d  = owner_q;
    waiter_d = waiter_q;
    valid_d  = valid_q;
    dest_d   = dest_q;
    data_d   = data_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (lock_if.lock_in_tvalid && in_rdy_q) begin
          tid_d   = lock_if.lock_in_tid;
          opc_d   = lock_if.lock_in_tdata[OPC_LSB +: 8];
          id_d    = lock_if.lock_in_tdata[ID_LSB +: 8];
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = IDLE;
        if (opc_q == LOCK_OP) begin
          if (!in_range) begin
            err_d   = 1'b1;
            dest_d  = tid_q;
            data_d  = resp_word(id_q, 1'b0);
            state_d = RESP;
          end else if (!sel_valid || sel_owner == tid_q) begin
            valid_d[lock_idx] = 1'b1;
            owner_d[lock_idx] = tid_q;
            dest_d  = tid_q;
            data_d  = resp_word(id_q, 1'b1);
            state_d = RESP;
          end else if (QUEUE_WAITERS != 0) begin
            // Parked: the requester hears back only when the lock is handed over.
            waiter_d[lock_idx][tid_q] = 1'b1;
          end else begin
            dest_d  = tid_q;
            data_d  = resp_word(id_q, 1'b0);
            state_d = RESP;
          end
        end else if (opc_q == UNLOCK_OP) begin
          if (in_range && sel_valid && sel_owner == tid_q) begin
            if (!pick_found) begin
              valid_d[lock_idx] = 1'b0;
            end else begin
              // Direct hand-over: valid stays set, so no one can slip in between.
              owner_d[lock_idx]            = pick_idx;
              waiter_d[lock_idx][pick_idx] = 1'b0;
              dest_d  = pick_idx;
              data_d  = resp_word(id_q, 1'b1);
              state_d = RESP;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end

      RESP: begin
        if (lock_if.lock_out_tready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_rdy_d  = (state_d == IDLE);
    out_vld_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tid_q     <= '0;
      opc_q     <= '0;
      id_q      <= '0;
      valid_q   <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      dest_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        owner_q[i]  <= '0;
        waiter_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      opc_q     <= opc_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
      dest_q    <= dest_d;
      data_q    <= data_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      waiter_q  <= waiter_d;
    end
  end

  assign lock_if.lock_in_tready  = in_rdy_q;
  assign lock_if.lock_out_tvalid = out_vld_q;
  assign lock_if.lock_out_tdest  = dest_q;
  assign lock_if.lock_out_tdata  = data_q;
  assign lock_if.lock_out_tlast  = out_vld_q;
  assign lock_busy               = valid_q;
  assign err                     = err_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_multi_lock_manager.sv
// Directed bench: a queued-waiter instance (A) and a busy-reply instance (B).
module tb_multi_lock_manager;
  import multi_lock_pkg::*;

  typedef struct {
    logic [7:0]  opc;
    logic [7:0]  id;
    logic [3:0]  tid;
    bit          resp;
    logic [3:0]  dest;
    logic [63:0] data;
    logic [3:0]  busy;
    bit          err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        sel;
  logic        in_valid;
  logic [3:0]  in_tid;
  logic [63:0] in_data;
  logic        out_tready;

  int total = 0;
  int bad   = 0;

  multi_lock_manager_if #(.MAX_ACCS(16)) bus_a ();
  multi_lock_manager_if #(.MAX_ACCS(16)) bus_b ();

  logic [3:0] busy_a, busy_b;
  logic       err_a, err_b;
  state_e     state_a, state_b;

  assign bus_a.lock_in_tvalid  = in_valid && !sel;
  assign bus_a.lock_in_tid     = in_tid;
  assign bus_a.lock_in_tdata   = in_data;
  assign bus_a.lock_out_tready = out_tready;
  assign bus_b.lock_in_tvalid  = in_valid && sel;
  assign bus_b.lock_in_tid     = in_tid;
  assign bus_b.lock_in_tdata   = in_data;
  assign bus_b.lock_out_tready = out_tready;

  multi_lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(4), .QUEUE_WAITERS(1)) dut_a (
    .clk(clk), .rstn(rstn), .lock_if(bus_a),
    .lock_busy(busy_a), .err(err_a), .dbg_state(state_a)
  );

  multi_lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(4), .QUEUE_WAITERS(0)) dut_b (
    .clk(clk), .rstn(rstn), .lock_if(bus_b),
    .lock_busy(busy_b), .err(err_b), .dbg_state(state_b)
  );

  logic        s_in_tready, s_tvalid, s_tlast, s_err;
  logic [3:0]  s_tdest, s_busy;
  logic [63:0] s_tdata;
  assign s_in_tready = sel ? bus_b.lock_in_tready  : bus_a.lock_in_tready;
  assign s_tvalid    = sel ? bus_b.lock_out_tvalid : bus_a.lock_out_tvalid;
  assign s_tlast     = sel ? bus_b.lock_out_tlast  : bus_a.lock_out_tlast;
  assign s_tdest     = sel ? bus_b.lock_out_tdest  : bus_a.lock_out_tdest;
  assign s_tdata     = sel ? bus_b.lock_out_tdata  : bus_a.lock_out_tdata;
  assign s_busy      = sel ? busy_b : busy_a;
  assign s_err       = sel ? err_b  : err_a;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Waits (bounded) for tready, transfers one request beat; returns at the
  // falling edge of the cycle after the handshake.
  task automatic send(input logic [7:0] opc, input logic [7:0] id, input logic [3:0] tid,
                      input string nm);
    int w = 0;
    while (!s_in_tready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_in_tready"}, 64'(s_in_tready), 64'd1);
    in_tid   = tid;
    in_data  = {48'h0, id, opc};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input vec_t v, input string nm);
    send(v.opc, v.id, v.tid, nm);
    chk({nm, "_tvalid_n1"}, 64'(s_tvalid), 64'd0);
    @(negedge clk);
    if (v.resp) begin
      chk({nm, "_tvalid_n2"}, 64'(s_tvalid), 64'd1);
      chk({nm, "_tdest"}, 64'(s_tdest), 64'(v.dest));
      chk({nm, "_tdata"}, s_tdata, v.data);
      chk({nm, "_tlast"}, 64'(s_tlast), 64'd1);
      @(negedge clk);
      chk({nm, "_tvalid_after"}, 64'(s_tvalid), 64'd0);
    end else begin
      chk({nm, "_no_resp"}, 64'(s_tvalid), 64'd0);
    end
    chk({nm, "_busy"}, 64'(s_busy), 64'(v.busy));
    chk({nm, "_err"}, 64'(s_err), 64'(v.err));
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{LOCK_OP,   8'd2, 4'd3,  1'b1, 4'd3,  64'h0201, 4'b0100, 1'b0};
    vecs[1]  = '{LOCK_OP,   8'd2, 4'd5,  1'b0, 4'd0,  64'h0,    4'b0100, 1'b0};
    vecs[2]  = '{LOCK_OP,   8'd2, 4'd1,  1'b0, 4'd0,  64'h0,    4'b0100, 1'b0};
    vecs[3]  = '{UNLOCK_OP, 8'd2, 4'd3,  1'b1, 4'd5,  64'h0201, 4'b0100, 1'b0};
    vecs[4]  = '{UNLOCK_OP, 8'd2, 4'd5,  1'b1, 4'd1,  64'h0201, 4'b0100, 1'b0};
    vecs[5]  = '{UNLOCK_OP, 8'd2, 4'd1,  1'b0, 4'd0,  64'h0,    4'b0000, 1'b0};
    vecs[6]  = '{LOCK_OP,   8'd0, 4'd6,  1'b1, 4'd6,  64'h0001, 4'b0001, 1'b0};
    vecs[7]  = '{LOCK_OP,   8'd0, 4'd6,  1'b1, 4'd6,  64'h0001, 4'b0001, 1'b0};
    vecs[8]  = '{LOCK_OP,   8'd3, 4'd15, 1'b1, 4'd15, 64'h0301, 4'b1001, 1'b0};
    vecs[9]  = '{UNLOCK_OP, 8'd0, 4'd6,  1'b0, 4'd0,  64'h0,    4'b1000, 1'b0};
    vecs[10] = '{UNLOCK_OP, 8'd0, 4'd7,  1'b0, 4'd0,  64'h0,    4'b1000, 1'b1};
    vecs[11] = '{LOCK_OP,   8'd9, 4'd2,  1'b1, 4'd2,  64'h0900, 4'b1000, 1'b1};
    vecs[12] = '{UNLOCK_OP, 8'd3, 4'd4,  1'b0, 4'd0,  64'h0,    4'b1000, 1'b1};
    vecs[13] = '{8'h05,     8'd3, 4'd15, 1'b0, 4'd0,  64'h0,    4'b1000, 1'b1};
    vecs[14] = '{UNLOCK_OP, 8'd3, 4'd15, 1'b0, 4'd0,  64'h0,    4'b0000, 1'b1};

    rstn = 1'b0; sel = 1'b0; in_valid = 1'b0; in_tid = '0; in_data = '0; out_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_tready", 64'(s_in_tready), 64'd0);
    chk("rst_tvalid",    64'(s_tvalid),    64'd0);
    chk("rst_tdata",     s_tdata,          64'd0);
    chk("rst_busy",      64'(s_busy),      64'd0);
    chk("rst_err",       64'(s_err),       64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) run(vecs[i], $sformatf("v%0d", i));

    // Response held under backpressure for 10 cycles, then exactly one beat.
    out_tready = 1'b0;
    send(LOCK_OP, 8'd1, 4'd2, "bp");
    @(negedge clk);
    chk("bp_tvalid", 64'(s_tvalid), 64'd1);
    chk("bp_tlast",  64'(s_tlast),  64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_tvalid", c), 64'(s_tvalid), 64'd1);
      chk($sformatf("bp_hold%0d_tdata", c),  s_tdata, 64'h0101);
      chk($sformatf("bp_hold%0d_tdest", c),  64'(s_tdest), 64'd2);
      chk($sformatf("bp_hold%0d_in_rdy", c), 64'(s_in_tready), 64'd0);
    end
    out_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_post%0d_tvalid", c), 64'(s_tvalid), 64'd0);
    end
    chk("bp_busy", 64'(s_busy), 64'b0010);

    // Park two waiters, start a hand-over, then reset while it sits in RESP.
    send(LOCK_OP, 8'd1, 4'd3, "park3");
    @(negedge clk);
    chk("park3_no_resp", 64'(s_tvalid), 64'd0);
    send(LOCK_OP, 8'd1, 4'd4, "park4");
    @(negedge clk);
    chk("park4_no_resp", 64'(s_tvalid), 64'd0);
    out_tready = 1'b0;
    send(UNLOCK_OP, 8'd1, 4'd2, "handover");
    @(negedge clk);
    chk("handover_tvalid", 64'(s_tvalid), 64'd1);
    chk("handover_tdest",  64'(s_tdest),  64'd3);
    chk("handover_tdata",  s_tdata,       64'h0101);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid",   64'(s_tvalid),    64'd0);
    chk("mid_rst_tdata",    s_tdata,          64'd0);
    chk("mid_rst_tdest",    64'(s_tdest),     64'd0);
    chk("mid_rst_tlast",    64'(s_tlast),     64'd0);
    chk("mid_rst_in_rdy",   64'(s_in_tready), 64'd0);
    chk("mid_rst_busy",     64'(s_busy),      64'd0);
    chk("mid_rst_err",      64'(s_err),       64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    out_tready = 1'b1;
    run('{LOCK_OP,   8'd1, 4'd4, 1'b1, 4'd4, 64'h0101, 4'b0010, 1'b0}, "post_rst_lock");
    run('{UNLOCK_OP, 8'd1, 4'd4, 1'b0, 4'd0, 64'h0,    4'b0000, 1'b0}, "post_rst_unlock");

    // Instance without waiter queue replies busy immediately.
    sel = 1'b1;
    @(negedge clk);
    run('{LOCK_OP, 8'd1, 4'd3, 1'b1, 4'd3, 64'h0101, 4'b0010, 1'b0}, "nq_lock");
    run('{LOCK_OP, 8'd1, 4'd4, 1'b1, 4'd4, 64'h0100, 4'b0010, 1'b0}, "nq_busy");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
